// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer read path: beat struct, buffer states,
// and the unique-ID width derivation used by the allocator and its consumers.
package rob_pkg;

    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    // Allocator IDs are {row, col}, each clog2(clog2(capacity)) bits wide.
    function automatic int uid_w(input int max_outstanding);
        int l2;
        l2 = $clog2(max_outstanding);
        return 2 * $clog2(l2);
    endfunction

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_beat_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/rob_skid_buffer.sv
// Two-entry FIFO-ordered valid/ready buffer of r_beat_t; the output is always
// the head register, so it holds stable under backpressure.
module rob_skid_buffer
    import rob_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  r_beat_t    i_beat,
    output logic       o_valid,
    input  logic       i_ready,
    output r_beat_t    o_beat,
    output buf_state_t o_state
);

    // Handshake: a transfer happens on a side exactly when valid & ready are
    // both high in the same cycle; ready is a pure decode of registered state.

    buf_state_t r_state;
    buf_state_t w_next_state;
    r_beat_t    r_head;
    r_beat_t    r_tail;
    logic       w_push;
    logic       w_pop;

    assign o_ready = (r_state != BUF_TWO);
    assign o_valid = (r_state != BUF_EMPTY);
    assign o_beat  = r_head;
    assign o_state = r_state;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BUF_EMPTY: begin
                if (w_push) begin
                    w_next_state = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (w_push && !w_pop) begin
                    w_next_state = BUF_TWO;
                end else if (w_pop && !w_push) begin
                    w_next_state = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_pop) begin
                    w_next_state = BUF_ONE;
                end
            end
            default: w_next_state = BUF_EMPTY;
        endcase
    end

    // The head is loaded by a push into an empty (or draining) head slot;
    // the tail only ever fills when the head is occupied and not popping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_push) begin
                        r_head <= i_beat;
                    end
                end
                BUF_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= i_beat;
                    end else if (w_push) begin
                        r_tail <= i_beat;
                    end
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                    end
                end
                default: begin
                    r_head <= r_head;
                end
            endcase
        end
    end

endmodule

// File: rtl/r_id_restorer.sv
// Read-response stage behind the ID allocator: restores original IDs, frees
// unique IDs on last beats, buffers toward the master and keeps statistics.
module r_id_restorer
    import rob_pkg::*;
#(
    parameter int ID_WIDTH        = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [ID_WIDTH-1:0]   s_rid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    output logic                  m_rvalid,
    input  logic                  m_rready,
    output logic [ID_WIDTH-1:0]   m_rid,
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            m_rresp,
    output logic                  m_rlast,
    output logic                  free_req,
    output logic [ID_WIDTH-1:0]   unique_id_to_free,
    input  logic [ID_WIDTH-1:0]   restored_id,
    output logic [CNT_WIDTH-1:0]  burst_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  bad_id_err
);

    localparam int UID_W = uid_w(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic       w_accept;
    logic       w_in_ready;
    logic       w_upper_nz;
    logic [ID_WIDTH-1:0] w_upper;
    r_beat_t    w_in_beat;
    r_beat_t    w_out_beat;
    buf_state_t w_buf_state;

    logic [CNT_WIDTH-1:0] r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 r_bad_id_err;

    assign s_rready          = w_in_ready;
    assign w_accept          = s_rvalid & w_in_ready;
    assign unique_id_to_free = s_rid;
    assign free_req          = w_accept & s_rlast;

    // Shift form keeps this legal even when UID_W covers the whole ID.
    assign w_upper    = s_rid >> UID_W;
    assign w_upper_nz = |w_upper;

    // restored_id is captured now, while the allocator row is still bound.
    assign w_in_beat.id   = restored_id;
    assign w_in_beat.data = s_rdata;
    assign w_in_beat.resp = s_rresp;
    assign w_in_beat.last = s_rlast;

    rob_skid_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (s_rvalid),
        .o_ready (w_in_ready),
        .i_beat  (w_in_beat),
        .o_valid (m_rvalid),
        .i_ready (m_rready),
        .o_beat  (w_out_beat),
        .o_state (w_buf_state)
    );

    assign m_rid   = w_out_beat.id;
    assign m_rdata = w_out_beat.data;
    assign m_rresp = w_out_beat.resp;
    assign m_rlast = w_out_beat.last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_cnt  <= '0;
            r_err_cnt    <= '0;
            r_bad_id_err <= 1'b0;
        end else if (w_accept) begin
            if (s_rlast && (r_burst_cnt != CNT_MAX)) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (s_rresp[1] && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_upper_nz) begin
                r_bad_id_err <= 1'b1;
            end
        end
    end

    assign burst_cnt  = r_burst_cnt;
    assign err_cnt    = r_err_cnt;
    assign bad_id_err = r_bad_id_err;

endmodule

// File: doc/r_id_restorer.md
# r_id_restorer

Read-response stage directly downstream of the reorder-buffer ID allocator. It accepts R beats from the slave tagged with allocator-issued unique IDs and looks up each beat's original ID through the allocator's free-port lookup. It pulses a free to the allocator on every accepted last beat. Restored beats go to the master through a 2-entry full-throughput buffer, and the block keeps saturating burst and error-response counters.

## Interface
- ID_WIDTH, 4, width of original and unique IDs; matches allocator.
- DATA_WIDTH, 32, R data width.
- MAX_OUTSTANDING, 16, allocator capacity. Derives ROW_W = COL_W = clog2(clog2(MAX_OUTSTANDING)) and UID_W = ROW_W+COL_W.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-high.
- s_rvalid, in, 1, slave beat valid.
- s_rready, out, 1, slave beat ready.
- s_rid, in, ID_WIDTH, unique ID of beat.
- s_rdata, in, DATA_WIDTH, beat data.
- s_rresp, in, 2, AXI response.
- s_rlast, in, 1, last beat of burst.
- m_rvalid, out, 1, master beat valid.
- m_rready, in, 1, master beat ready.
- m_rid, out, ID_WIDTH, restored original ID.
- m_rdata, out, DATA_WIDTH, beat data.
- m_rresp, out, 2, response.
- m_rlast, out, 1, last flag.
- free_req, out, 1, free pulse to allocator.
- unique_id_to_free, out, ID_WIDTH, lookup/free index to allocator.
- restored_id, in, ID_WIDTH, combinational original-ID lookup from allocator.
- burst_cnt, out, CNT_WIDTH, completed bursts, saturating.
- err_cnt, out, CNT_WIDTH, beats with s_rresp[1]=1, saturating.
- bad_id_err, out, 1, sticky: an accepted beat had nonzero s_rid[ID_WIDTH-1:UID_W].

## Operation
- Accept = s_rvalid & s_rready.
- unique_id_to_free = s_rid at all times. The lookup needs no free_req.
- free_req = accept & s_rlast, combinational, same cycle as acceptance. Non-last beats never free.
- On accept, the block captures the beat {restored_id, s_rdata, s_rresp, s_rlast} into the buffer. restored_id is sampled in the acceptance cycle, before the allocator unbinds the row.
- Buffer FSM has three states:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> TWO; pop without accept -> EMPTY; accept and pop -> ONE.
  - TWO: pop -> ONE. No accept is possible in TWO.
- Pop = m_rvalid & m_rready. Order is strictly FIFO. m_* is driven from the head entry.
- s_rready = (state != TWO), a registered-state decode. m_rvalid = (state != EMPTY).
- Counters update on accept:
  - burst_cnt += 1 when s_rlast.
  - err_cnt += 1 when s_rresp[1].
  - Both saturate at all-ones and hold there.
- bad_id_err is set on an accepted beat with out-of-range upper bits. It clears only on rst. That beat is still forwarded and freed; garbage-in, no drop.
- Beats from different IDs may interleave. The block keeps no per-ID state.

## Timing
- Reset values: state EMPTY, so s_rready=1 and m_rvalid=0. m_rid/m_rdata/m_rresp/m_rlast=0, free_req=0, burst_cnt=0, err_cnt=0, bad_id_err=0.
- Latency: a beat accepted in cycle N is visible on m_* in cycle N+1.
- Throughput: 1 beat/cycle sustained when m_rready=1.
- Backpressure: after m_rready drops, at most 2 beats are held, then s_rready=0 from the next cycle. s_rready returns to 1 in the cycle after the first pop.
- m_* holds stable while m_rvalid=1 and m_rready=0 (AXI rule).
- Simultaneous accept and pop in ONE: the head is replaced by the new beat and the state stays ONE.
- Reset mid-operation: buffered beats are discarded, no free_req is issued for them, and the counters clear.

## Structure
- The shared package rob_pkg holds:
  - function uid_w(MAX_OUTSTANDING);
  - r_beat_t packed struct {id, data, resp, last}, parameterised via package localparams matching the defaults;
  - buffer-state enum {BUF_EMPTY, BUF_ONE, BUF_TWO}.
- One sub-module: rob_skid_buffer, a generic 2-entry valid/ready buffer of r_beat_t. r_id_restorer wraps it with the lookup, free, counter and error logic.

## Test plan
- Reset then single beat: s_rid=0x5, restored_id=0xA, s_rlast=1, m_rready=1. Expect free_req=1 with unique_id_to_free=0x5 in cycle N, then m_rid=0xA and m_rlast=1 in N+1, and burst_cnt=1.
- 4-beat burst, s_rid=0x2, m_rready=1 throughout. Expect 4 beats in order with no bubbles, free_req only on beat 4, burst_cnt=1.
- Backpressure: m_rready=0 while 3 beats are offered. Expect 2 accepted, s_rready=0 from the next cycle, the third beat held upstream. Raise m_rready: expect 3 beats out in order and s_rready=1 one cycle after the first pop.
- Error responses: beats with s_rresp=2'b10 and 2'b11, then 2'b00. Expect err_cnt=2. Preload near saturation (CNT_WIDTH=2) and check err_cnt stays at 3.
- Bad ID: s_rid=0x8 with UID_W=2. Expect bad_id_err=1 sticky, beat still forwarded, free_req pulsed. Assert rst mid-stream with 2 beats buffered: expect immediate m_rvalid=0, s_rready=1, all counters 0.
